// File: rtl/dabbler_arbiter.sv
// dabbler_arbiter
// Round-robin arbiter/sequencer sharing one clocked 16-bit double-dabble
// binary-to-BCD converter between NCH requesters. The winner's operand is
// captured in IDLE, the converter is started in LOAD, its finish level is
// awaited in WAIT and the 20-bit BCD result is returned with a one-cycle
// one-hot ack in DONE.
//
// Optional feature: define DABBLER_ARB_TIMEOUT_EN to add a WAIT watchdog
// (TIMEOUT_CYCLES) and the err output. Undefined, WAIT waits indefinitely.
//
// Handshake: a requester raises req[i] with a stable operand on its
// bin_in slice and holds both until ack[i] pulses; bcd_out is valid only in
// that ack cycle. Dropping req[i] before the DONE cycle discards the result.
// Converter side: dd_start pulses one cycle with dd_bin already stable;
// dd_bin holds until finish; dd_finish is ignored in the first WAIT cycle
// because it may still be high from the previous conversion.

module dabbler_arbiter #(
  parameter int NCH            = 4,
  parameter int PTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req,
  input  logic [16*NCH-1:0]  bin_in,
  output logic [NCH-1:0]     ack,
  output logic [19:0]        bcd_out,
  output logic               busy,
  output logic [15:0]        dd_bin,
  output logic               dd_start,
  input  logic [19:0]        dd_bcd,
  input  logic               dd_finish,
`ifdef DABBLER_ARB_TIMEOUT_EN
  output logic               err,
`endif
  output logic [1:0]         state_dbg
);

  if (NCH < 2 || NCH > 8 || (2**PTR_W) < NCH || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("dabbler_arbiter: parameter set out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               wait_first;
  logic [19:0]        result;
  logic               finish_ok;

`ifdef DABBLER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]      wcnt;
  logic               timed_out;
  logic               timeout_hit;
`endif

  // A finish is only trusted from the second WAIT cycle on
  assign finish_ok = (state == S_WAIT) && !wait_first && dd_finish;

`ifdef DABBLER_ARB_TIMEOUT_EN
  // Watchdog fires in the TIMEOUT_CYCLES-th WAIT cycle unless finish wins
  assign timeout_hit = (state == S_WAIT) && !finish_ok &&
                       (wcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin search: lowest offset from ptr (mod NCH) with req set wins
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        grant_idx   = idx[PTR_W-1:0];
        grant_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_found) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (finish_ok) state_nxt = S_DONE;
`ifdef DABBLER_ARB_TIMEOUT_EN
        else if (timeout_hit) state_nxt = S_DONE;
`endif
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: winner/operand capture, WAIT bookkeeping, result, pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      win        <= '0;
      dd_bin     <= '0;
      wait_first <= 1'b0;
      result     <= '0;
`ifdef DABBLER_ARB_TIMEOUT_EN
      wcnt       <= '0;
      timed_out  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            win    <= grant_idx;
            dd_bin <= bin_in[16*grant_idx +: 16];
          end
        end
        S_LOAD: begin
          wait_first <= 1'b1;
`ifdef DABBLER_ARB_TIMEOUT_EN
          wcnt       <= '0;
          timed_out  <= 1'b0;
`endif
        end
        S_WAIT: begin
          wait_first <= 1'b0;
`ifdef DABBLER_ARB_TIMEOUT_EN
          wcnt       <= wcnt + 1'b1;
`endif
          if (finish_ok) begin
            result <= dd_bcd;
          end
`ifdef DABBLER_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            result    <= '0;
            timed_out <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          ptr <= (win == PTR_W'(NCH - 1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: ack/result only in DONE, and only if the winner still requests
  always_comb begin
    ack     = '0;
    bcd_out = '0;
    if (state == S_DONE) begin
      bcd_out = result;
      if (req[win]) ack[win] = 1'b1;
    end
  end

`ifdef DABBLER_ARB_TIMEOUT_EN
  // Timeout flag is visible only alongside an issued ack
  always_comb begin
    err = 1'b0;
    if (state == S_DONE && timed_out && req[win]) err = 1'b1;
  end
`endif

  assign dd_start  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
